// File: rtl/mem_access_stage_hs.sv
// mem_access_stage_hs: MEM pipeline stage with sub-word load/store support and
// a req/gnt/rvalid data-memory handshake. One op in flight; upstream is
// stalled (ready_o=0) until the memory side completes. Results are registered
// into MEM/WB with a single-cycle wb_valid_o pulse per retired op.
// ADDR_W is expected to be <= XLEN (the address is taken from alu_result_i).
module mem_access_stage_hs #(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic                  reg_write_i,
  input  logic                  mem_to_reg_i,
  input  logic                  branch_i,
  input  logic                  zero_i,
  input  logic [2:0]            funct3_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic [XLEN-1:0]       alu_result_i,
  input  logic [XLEN-1:0]       store_data_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_W-1:0]     dmem_addr_o,
  output logic [XLEN/8-1:0]     dmem_be_o,
  output logic [XLEN-1:0]       dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [XLEN-1:0]       dmem_rdata_i,
  output logic                  pcsrc_o,
  output logic                  access_fault_o,
  output logic                  wb_valid_o,
  output logic                  wb_reg_write_o,
  output logic                  wb_mem_to_reg_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o,
  output logic [XLEN-1:0]       wb_read_data_o,
  output logic [XLEN-1:0]       wb_alu_result_o
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              w_idle;
  logic              w_accept;
  logic              w_mem_op;
  logic              w_legal;
  logic              w_misaligned;
  logic              w_fault;
  logic [OFF_W-1:0]  w_off;
  logic [BE_W-1:0]   w_be;
  logic [XLEN-1:0]   w_rshift;
  logic [XLEN-1:0]   w_load_data;

  logic              r_we;
  logic [2:0]        r_funct3;
  logic [OFF_W-1:0]  r_off;
  logic [ADDR_W-1:0] r_addr;
  logic [BE_W-1:0]   r_be;
  logic [XLEN-1:0]   r_wdata;
  logic [REG_ADDR_W-1:0] r_rd;
  logic              r_reg_write;
  logic              r_mem_to_reg;
  logic [XLEN-1:0]   r_alu_result;

  logic              r_wb_valid;
  logic              r_wb_reg_write;
  logic              r_wb_mem_to_reg;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic [XLEN-1:0]   r_wb_read_data;
  logic [XLEN-1:0]   r_wb_alu_result;
  logic              r_fault;

  // ready depends only on state, so accept never loops back through outputs
  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = valid_i & w_idle;
  assign w_mem_op = mem_read_i | mem_write_i;
  assign w_off    = alu_result_i[OFF_W-1:0];
  assign w_fault  = w_mem_op & (~w_legal | w_misaligned);
  assign pcsrc_o  = w_accept & branch_i & zero_i;

  // Legality of funct3 for the requested access; double-word forms only on RV64
  always_comb begin
    w_legal = 1'b0;
    if (mem_read_i & mem_write_i) begin
      w_legal = 1'b0;
    end else if (mem_read_i) begin
      case (funct3_i)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
        3'b011, 3'b110:                         w_legal = (XLEN == 64);
        default:                                w_legal = 1'b0;
      endcase
    end else if (mem_write_i) begin
      case (funct3_i)
        3'b000, 3'b001, 3'b010: w_legal = 1'b1;
        3'b011:                 w_legal = (XLEN == 64);
        default:                w_legal = 1'b0;
      endcase
    end else begin
      w_legal = 1'b1;
    end
  end

  // Natural-alignment check by access size (funct3[1:0])
  always_comb begin
    w_misaligned = 1'b0;
    case (funct3_i[1:0])
      2'b01:   w_misaligned = (alu_result_i[0] != 1'b0);
      2'b10:   w_misaligned = (alu_result_i[1:0] != 2'b00);
      2'b11:   w_misaligned = (alu_result_i[2:0] != 3'b000);
      default: w_misaligned = 1'b0;
    endcase
  end

  // Byte-enable mask for the access size, placed at the byte offset
  always_comb begin
    w_be = {BE_W{1'b0}};
    case (funct3_i[1:0])
      2'b00:   w_be = BE_W'(4'h1) << w_off;
      2'b01:   w_be = BE_W'(4'h3) << w_off;
      2'b10:   w_be = BE_W'(4'hF) << w_off;
      default: w_be = {BE_W{1'b1}};
    endcase
  end

  // Extract and extend the addressed lane from the returned word
  always_comb begin
    w_rshift    = dmem_rdata_i >> {r_off, 3'b000};
    w_load_data = {XLEN{1'b0}};
    case (r_funct3)
      3'b000:  w_load_data = XLEN'($signed(w_rshift[7:0]));
      3'b001:  w_load_data = XLEN'($signed(w_rshift[15:0]));
      3'b010:  w_load_data = XLEN'($signed(w_rshift[31:0]));
      3'b011:  w_load_data = w_rshift;
      3'b100:  w_load_data = XLEN'(w_rshift[7:0]);
      3'b101:  w_load_data = XLEN'(w_rshift[15:0]);
      3'b110:  w_load_data = XLEN'(w_rshift[31:0]);
      default: w_load_data = {XLEN{1'b0}};
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept & w_mem_op & ~w_fault) w_state_nxt = S_REQ;
        else                                w_state_nxt = S_IDLE;
      end
      S_REQ: begin
        if (dmem_gnt_i) w_state_nxt = r_we ? S_IDLE : S_RESP;
        else            w_state_nxt = S_REQ;
      end
      S_RESP: begin
        if (dmem_rvalid_i) w_state_nxt = S_IDLE;
        else               w_state_nxt = S_RESP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: request fields are driven only while the request is open
  always_comb begin
    ready_o      = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = {ADDR_W{1'b0}};
    dmem_be_o    = {BE_W{1'b0}};
    dmem_wdata_o = {XLEN{1'b0}};
    case (r_state)
      S_IDLE: ready_o = 1'b1;
      S_REQ: begin
        dmem_req_o   = 1'b1;
        dmem_we_o    = r_we;
        dmem_addr_o  = r_addr;
        dmem_be_o    = r_be;
        dmem_wdata_o = r_wdata;
      end
      S_RESP:  ready_o = 1'b0;
      default: ready_o = 1'b0;
    endcase
  end

  // Capture op fields on accept; held stable through REQ/RESP
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_we         <= 1'b0;
      r_funct3     <= 3'b000;
      r_off        <= {OFF_W{1'b0}};
      r_addr       <= {ADDR_W{1'b0}};
      r_be         <= {BE_W{1'b0}};
      r_wdata      <= {XLEN{1'b0}};
      r_rd         <= {REG_ADDR_W{1'b0}};
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_result <= {XLEN{1'b0}};
    end else if (w_accept) begin
      r_we         <= mem_write_i;
      r_funct3     <= funct3_i;
      r_off        <= w_off;
      r_addr       <= {alu_result_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      r_be         <= w_be;
      r_wdata      <= store_data_i << {w_off, 3'b000};
      r_rd         <= rd_i;
      r_reg_write  <= reg_write_i;
      r_mem_to_reg <= mem_to_reg_i;
      r_alu_result <= alu_result_i;
    end
  end

  // MEM/WB register: one-cycle retire pulse for ALU ops, faults, stores and loads
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_wb_valid      <= 1'b0;
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_to_reg <= 1'b0;
      r_wb_rd         <= {REG_ADDR_W{1'b0}};
      r_wb_read_data  <= {XLEN{1'b0}};
      r_wb_alu_result <= {XLEN{1'b0}};
      r_fault         <= 1'b0;
    end else begin
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_fault        <= 1'b0;
      if (w_accept && (!w_mem_op || w_fault)) begin
        r_wb_valid      <= 1'b1;
        r_wb_reg_write  <= reg_write_i & ~w_fault;
        r_wb_mem_to_reg <= mem_to_reg_i;
        r_wb_rd         <= rd_i;
        r_wb_read_data  <= {XLEN{1'b0}};
        r_wb_alu_result <= alu_result_i;
        r_fault         <= w_fault;
      end else if ((r_state == S_REQ) && dmem_gnt_i && r_we) begin
        r_wb_valid      <= 1'b1;
        r_wb_reg_write  <= r_reg_write;
        r_wb_mem_to_reg <= r_mem_to_reg;
        r_wb_rd         <= r_rd;
        r_wb_read_data  <= {XLEN{1'b0}};
        r_wb_alu_result <= r_alu_result;
      end else if ((r_state == S_RESP) && dmem_rvalid_i) begin
        r_wb_valid      <= 1'b1;
        r_wb_reg_write  <= r_reg_write;
        r_wb_mem_to_reg <= r_mem_to_reg;
        r_wb_rd         <= r_rd;
        r_wb_read_data  <= w_load_data;
        r_wb_alu_result <= r_alu_result;
      end
    end
  end

  assign wb_valid_o      = r_wb_valid;
  assign wb_reg_write_o  = r_wb_reg_write;
  assign wb_mem_to_reg_o = r_wb_mem_to_reg;
  assign wb_rd_o         = r_wb_rd;
  assign wb_read_data_o  = r_wb_read_data;
  assign wb_alu_result_o = r_wb_alu_result;
  assign access_fault_o  = r_fault;

endmodule

// File: tb/tb_mem_access_stage_hs.sv
// Directed bench for mem_access_stage_hs (RV32): expected MEM/WB records are
// queued when an op is driven and compared whenever wb_valid_o fires.
module tb_mem_access_stage_hs;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i, ready_o;
  logic        mem_read_i, mem_write_i, reg_write_i, mem_to_reg_i;
  logic        branch_i, zero_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic [31:0] alu_result_i, store_data_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        pcsrc_o, access_fault_o, wb_valid_o, wb_reg_write_o, wb_mem_to_reg_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_read_data_o, wb_alu_result_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic        fault;
  } wb_exp_t;

  wb_exp_t sb[$];

  mem_access_stage_hs #(.XLEN(32), .ADDR_W(32), .REG_ADDR_W(5)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .reg_write_i(reg_write_i),
    .mem_to_reg_i(mem_to_reg_i), .branch_i(branch_i), .zero_i(zero_i),
    .funct3_i(funct3_i), .rd_i(rd_i), .alu_result_i(alu_result_i),
    .store_data_i(store_data_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .pcsrc_o(pcsrc_o), .access_fault_o(access_fault_o), .wb_valid_o(wb_valid_o),
    .wb_reg_write_o(wb_reg_write_o), .wb_mem_to_reg_o(wb_mem_to_reg_o),
    .wb_rd_o(wb_rd_o), .wb_read_data_o(wb_read_data_o), .wb_alu_result_o(wb_alu_result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_wb(input logic [4:0] rd, input logic rw, input logic m2r,
                        input logic [31:0] rdata, input logic [31:0] alu, input logic fault);
    wb_exp_t e;
    e.rd = rd; e.rw = rw; e.m2r = m2r; e.rdata = rdata; e.alu = alu; e.fault = fault;
    sb.push_back(e);
  endtask

  // advance one cycle and check any retirement against the scoreboard
  task automatic tick();
    wb_exp_t e;
    @(posedge clk_i);
    #1;
    if (wb_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", wb_valid_o, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_rd", wb_rd_o, e.rd);
        chk("wb_reg_write", wb_reg_write_o, e.rw);
        chk("wb_mem_to_reg", wb_mem_to_reg_o, e.m2r);
        chk("wb_read_data", wb_read_data_o, e.rdata);
        chk("wb_alu_result", wb_alu_result_o, e.alu);
        chk("wb_fault", access_fault_o, e.fault);
      end
    end else begin
      chk("idle_reg_write", wb_reg_write_o, 64'd0);
      chk("idle_fault", access_fault_o, 64'd0);
    end
  endtask

  task automatic set_op(input logic mr, input logic mw, input logic rw, input logic m2r,
                        input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] sd);
    valid_i = 1'b1; mem_read_i = mr; mem_write_i = mw; reg_write_i = rw;
    mem_to_reg_i = m2r; funct3_i = f3; rd_i = rd; alu_result_i = alu;
    store_data_i = sd; branch_i = 1'b0; zero_i = 1'b0;
  endtask

  task automatic clr_op();
    valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; reg_write_i = 1'b0;
    mem_to_reg_i = 1'b0; branch_i = 1'b0; zero_i = 1'b0; funct3_i = 3'd0;
    rd_i = 5'd0; alu_result_i = 32'd0; store_data_i = 32'd0;
  endtask

  task automatic do_alu(input logic [4:0] rd, input logic [31:0] alu);
    set_op(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, rd, alu, 32'd0);
    #1 chk("alu_ready", ready_o, 64'd1);
    exp_wb(rd, 1'b1, 1'b0, 32'd0, alu, 1'b0);
    tick();
    clr_op();
    chk("alu_wb_lat1", wb_valid_o, 64'd1);
    #1 chk("alu_ready_after", ready_o, 64'd1);
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                          input int waits, input logic [3:0] be, input logic [31:0] wdata);
    set_op(1'b0, 1'b1, 1'b0, 1'b0, f3, 5'd0, addr, data);
    #1 chk("st_ready", ready_o, 64'd1);
    exp_wb(5'd0, 1'b0, 1'b0, 32'd0, addr, 1'b0);
    tick();
    clr_op();
    for (int i = 0; i <= waits; i++) begin
      #1;
      chk("st_req", dmem_req_o, 64'd1);
      chk("st_we", dmem_we_o, 64'd1);
      chk("st_addr", dmem_addr_o, {addr[31:2], 2'b00});
      chk("st_be", dmem_be_o, be);
      chk("st_wdata", dmem_wdata_o, wdata);
      chk("st_stall_ready", ready_o, 64'd0);
      if (i == 0) begin
        valid_i = 1'b1; branch_i = 1'b1; zero_i = 1'b1;
        #1 chk("pcsrc_stall", pcsrc_o, 64'd0);
        valid_i = 1'b0; branch_i = 1'b0; zero_i = 1'b0;
      end
      if (i == waits) dmem_gnt_i = 1'b1;
      tick();
    end
    dmem_gnt_i = 1'b0;
    chk("st_wb_lat", wb_valid_o, 64'd1);
    #1 chk("st_req_done", dmem_req_o, 64'd0);
    chk("st_ready_done", ready_o, 64'd1);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [3:0] be, input logic [31:0] exp_data);
    set_op(1'b1, 1'b0, 1'b1, 1'b1, f3, 5'd7, addr, 32'd0);
    dmem_gnt_i = 1'b1;
    #1 chk("ld_ready", ready_o, 64'd1);
    exp_wb(5'd7, 1'b1, 1'b1, exp_data, addr, 1'b0);
    tick();
    clr_op();
    #1;
    chk("ld_req", dmem_req_o, 64'd1);
    chk("ld_we", dmem_we_o, 64'd0);
    chk("ld_addr", dmem_addr_o, {addr[31:2], 2'b00});
    chk("ld_be", dmem_be_o, be);
    tick();
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = rdata;
    #1 chk("ld_resp_req", dmem_req_o, 64'd0);
    chk("ld_resp_ready", ready_o, 64'd0);
    tick();
    dmem_rvalid_i = 1'b0;
    chk("ld_wb_lat", wb_valid_o, 64'd1);
  endtask

  task automatic do_fault(input logic mr, input logic mw, input logic [2:0] f3,
                          input logic [31:0] addr);
    set_op(mr, mw, 1'b1, mr, f3, 5'd9, addr, 32'h5555_5555);
    #1 chk("flt_ready", ready_o, 64'd1);
    exp_wb(5'd9, 1'b0, mr, 32'd0, addr, 1'b1);
    tick();
    clr_op();
    chk("flt_pulse", access_fault_o, 64'd1);
    #1 chk("flt_no_req", dmem_req_o, 64'd0);
    chk("flt_ready_after", ready_o, 64'd1);
    tick();
  endtask

  initial begin
    reset_i = 1'b0;
    clr_op();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;
    tick();
    tick();
    chk("rst_ready", ready_o, 64'd1);
    chk("rst_req", dmem_req_o, 64'd0);
    chk("rst_wb_valid", wb_valid_o, 64'd0);
    chk("rst_pcsrc", pcsrc_o, 64'd0);
    reset_i = 1'b1;
    tick();

    // 1: plain ALU op, one-cycle latency
    do_alu(5'd5, 32'h0000_1234);
    tick();

    // stray handshake inputs while idle must not retire anything
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    tick();

    // 2: stores, including a delayed grant
    do_store(3'b000, 32'h0000_0103, 32'h0000_00AB, 2, 4'h8, 32'hAB00_0000);
    do_store(3'b001, 32'h0000_0102, 32'h1234_BEEF, 0, 4'hC, 32'hBEEF_0000);
    do_store(3'b010, 32'h0000_0108, 32'hDEAD_BEEF, 1, 4'hF, 32'hDEAD_BEEF);

    // 3: loads with sign/zero extension
    do_load(3'b001, 32'h0000_0102, 32'h8001_5A5A, 4'hC, 32'hFFFF_8001);
    do_load(3'b101, 32'h0000_0102, 32'h8001_5A5A, 4'hC, 32'h0000_8001);
    do_load(3'b000, 32'h0000_0103, 32'h8011_2233, 4'h8, 32'hFFFF_FF80);
    do_load(3'b100, 32'h0000_0103, 32'h8011_2233, 4'h8, 32'h0000_0080);
    do_load(3'b000, 32'h0000_0101, 32'h0000_7F00, 4'h2, 32'h0000_007F);
    do_load(3'b010, 32'h0000_0104, 32'h89AB_CDEF, 4'hF, 32'h89AB_CDEF);

    // 4: faults - misaligned, illegal funct3, read+write together
    do_fault(1'b1, 1'b0, 3'b010, 32'h0000_0101);
    do_fault(1'b0, 1'b1, 3'b001, 32'h0000_0103);
    do_fault(1'b1, 1'b0, 3'b011, 32'h0000_0100);
    do_fault(1'b1, 1'b1, 3'b010, 32'h0000_0100);

    // 5: branch taken in IDLE
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
    branch_i = 1'b1; zero_i = 1'b1;
    #1 chk("pcsrc_idle", pcsrc_o, 64'd1);
    zero_i = 1'b0;
    #1 chk("pcsrc_not_zero", pcsrc_o, 64'd0);
    zero_i = 1'b1;
    exp_wb(5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    clr_op();
    tick();

    // 6: reset during RESP drops the load
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 5'd3, 32'h0000_0200, 32'd0);
    dmem_gnt_i = 1'b1;
    tick();
    clr_op();
    tick();
    dmem_gnt_i = 1'b0;
    #1 chk("rst6_in_resp", ready_o, 64'd0);
    reset_i = 1'b0;
    #1 chk("rst6_req", dmem_req_o, 64'd0);
    chk("rst6_ready", ready_o, 64'd1);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'hCAFE_F00D;
    tick();
    chk("rst6_no_wb", wb_valid_o, 64'd0);
    reset_i = 1'b1;
    tick();
    dmem_rvalid_i = 1'b0;
    tick();
    do_alu(5'd11, 32'h0000_55AA);
    tick();

    chk("sb_empty", sb.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
